apb_i2s_mc_regfile: RTL and testbench

- Parametrised multi-channel APB register block for the I2S transmitter; successor to the fixed two-channel CR/SR/TXR/TXL map.
- Holds control, status and interrupt registers, plus one transmit FIFO per channel.
- Presents per-channel valid/ready sample streams to the I2S serializer and drives a single level interrupt.

---
 rtl/apb_i2s_mc_regfile.sv | 156 +++++++++++++++
 tb/tb_apb_i2s_mc_regfile.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2s_mc_regfile.sv
// APB register block for the multi-channel I2S transmitter: CR/SR/IER/ISR,
// one transmit FIFO per channel, and per-channel sample streams with a level irq.
module apb_i2s_mc_regfile #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDR_W-1:0]        PADDR,
  input  logic [31:0]              PWDATA,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic                     i2s_enable,
  output logic [1:0]               sample_width,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic                     irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IRQ_W = 2 * NUM_CH;

  logic              access, wr_acc, rd_acc;
  logic              cr_hit, sr_hit, ier_hit, isr_hit, mapped;
  logic [NUM_CH-1:0] tx_hit;
  logic [NUM_CH-1:0] empty, full, push, pop, ovf_set, unr_set;
  logic              cr_enable, flush;
  logic [1:0]        cr_width;
  logic [IRQ_W-1:0]  ier, isr, isr_clr;
  logic [31:0]       sr_val;
  logic [DATA_W-1:0] push_data;
  int                keep_bits;

  // Outputs are gated by reset so PRDATA/PSLVERR read 0 even mid-access.
  assign access = PSEL & PENABLE & PRESETn;
  assign wr_acc = access & PWRITE;
  assign rd_acc = access & ~PWRITE;

  assign cr_hit  = (PADDR == ADDR_W'(32'h00));
  assign sr_hit  = (PADDR == ADDR_W'(32'h04));
  assign ier_hit = (PADDR == ADDR_W'(32'h08));
  assign isr_hit = (PADDR == ADDR_W'(32'h0C));
  assign mapped  = cr_hit | sr_hit | ier_hit | isr_hit | (|tx_hit);

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~mapped | (PWRITE & sr_hit) | (PWRITE & (|(tx_hit & full))));

  assign flush        = wr_acc & cr_hit & PWDATA[3];
  assign i2s_enable   = cr_enable;
  assign sample_width = cr_width;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cr_enable <= 1'b0;
      cr_width  <= 2'd0;
      ier       <= '0;
    end else begin
      if (wr_acc && cr_hit) begin
        cr_enable <= PWDATA[0];
        cr_width  <= PWDATA[2:1];
      end
      if (wr_acc && ier_hit) ier <= PWDATA[IRQ_W-1:0];
    end
  end

  // ISR: underrun bits low, overflow bits high; a same-cycle set beats W1C.
  assign unr_set = {NUM_CH{cr_enable}} & ch_ready & empty;
  assign isr_clr = (wr_acc && isr_hit) ? PWDATA[IRQ_W-1:0] : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) isr <= '0;
    else          isr <= (isr & ~isr_clr) | {ovf_set, unr_set};
  end

  assign irq = |(isr & ier);

  always_comb begin
    sr_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sr_val[2*i]   = empty[i];
      sr_val[2*i+1] = full[i];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      if (cr_hit)       PRDATA = {28'd0, 1'b0, cr_width, cr_enable};
      else if (sr_hit)  PRDATA = sr_val;
      else if (ier_hit) PRDATA = 32'(ier);
      else if (isr_hit) PRDATA = 32'(isr);
    end
  end

  // Width 3 is reserved and behaves as 32 bits.
  always_comb begin
    case (cr_width)
      2'd0:    keep_bits = 16;
      2'd1:    keep_bits = 24;
      default: keep_bits = 32;
    endcase
    for (int b = 0; b < DATA_W; b++) push_data[b] = PWDATA[b] & (b < keep_bits);
  end

  // Stream handshake: ch_valid[i] means the head of FIFO i is presented on
  // ch_data; a sample transfers on a clock edge where ch_valid[i]&ch_ready[i].
  assign ch_valid = {NUM_CH{cr_enable}} & ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    assign tx_hit[g]  = (PADDR == ADDR_W'(32'h10 + 4 * g));
    assign empty[g]   = (cnt == '0);
    assign full[g]    = (cnt == CNT_W'(FIFO_DEPTH));
    assign push[g]    = wr_acc & tx_hit[g] & ~full[g];
    assign ovf_set[g] = wr_acc & tx_hit[g] & full[g];
    assign pop[g]     = ch_valid[g] & ch_ready[g];
    assign ch_data[g*DATA_W +: DATA_W] = mem[rd_ptr];

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      end else if (flush) begin
        // Flush is a CR write, so no push can coincide; pops are dropped.
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[g]) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop[g]) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[g], pop[g]})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_i2s_mc_regfile.sv
// Bench for apb_i2s_mc_regfile: register vector table, FIFO scoreboard on the
// sample streams, and directed sequences for reset, overflow, wrap and flush.
module tb_apb_i2s_mc_regfile;

  logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        i2s_enable;
  logic [1:0]  sample_width;
  logic [63:0] ch_data;
  logic [1:0]  ch_valid, ch_ready;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [1:0]  model_width;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[20];

  apb_i2s_mc_regfile #(.NUM_CH(2), .DATA_W(32), .FIFO_DEPTH(8), .ADDR_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .i2s_enable(i2s_enable), .sample_width(sample_width), .ch_data(ch_data),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .irq(irq)
  );

  // Clock and watchdog
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask(input logic [31:0] v, input logic [1:0] w);
    case (w)
      2'd0:    return v & 32'h0000_FFFF;
      2'd1:    return v & 32'h00FF_FFFF;
      default: return v;
    endcase
  endfunction

  // Driver tasks
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [1:0] rdy_acc, output logic [31:0] rd, output logic err);
    logic [1:0] rdy_save;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    rdy_save = ch_ready;
    ch_ready = ch_ready | rdy_acc;
    @(negedge PCLK);
    rd = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    ch_ready = rdy_save;
  endtask

  task automatic apb_chk(input string name, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb(wr, addr, wd, 2'b00, rd, err);
    check({name, "_rd"}, rd, exp_rd);
    check({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic write_cr(input logic [31:0] v);
    apb_chk("cr_wr", 1'b1, 8'h00, v, 32'h0, 1'b0);
    model_width = v[2:1];
  endtask

  task automatic push_tx(input int ch, input logic [31:0] v, input logic exp_err,
                         input logic [1:0] rdy_acc);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, 8'(16 + 4 * ch), v, rdy_acc, rd, err);
    check("push_err", 32'(err), 32'(exp_err));
    if (!exp_err) begin
      if (ch == 0) exp_q0.push_back(mask(v, model_width));
      else         exp_q1.push_back(mask(v, model_width));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
    end
    repeat (2) @(posedge PCLK);
    #1;
    check("drain_q0", 32'(exp_q0.size()), 32'h0);
    check("drain_q1", 32'(exp_q1.size()), 32'h0);
  endtask

  // Scoreboard: compare each transferred sample with the queue head
  always @(negedge PCLK) begin
    if (PRESETn && ch_valid[0] && ch_ready[0]) begin
      if (exp_q0.size() == 0) check("ch0_stale", ch_data[31:0], 32'hDEAD_0000);
      else                    check("ch0_data", ch_data[31:0], exp_q0.pop_front());
    end
    if (PRESETn && ch_valid[1] && ch_ready[1]) begin
      if (exp_q1.size() == 0) check("ch1_stale", ch_data[63:32], 32'hDEAD_0001);
      else                    check("ch1_data", ch_data[63:32], exp_q1.pop_front());
    end
  end

  initial begin
    logic [31:0] rd;
    logic        err;

    tbl[0]  = '{1'b0, 8'h00, 32'h0,         32'h0, 1'b0};
    tbl[1]  = '{1'b0, 8'h04, 32'h0,         32'h5, 1'b0};
    tbl[2]  = '{1'b0, 8'h08, 32'h0,         32'h0, 1'b0};
    tbl[3]  = '{1'b0, 8'h0C, 32'h0,         32'h0, 1'b0};
    tbl[4]  = '{1'b0, 8'h3C, 32'h0,         32'h0, 1'b1};
    tbl[5]  = '{1'b0, 8'h18, 32'h0,         32'h0, 1'b1};
    tbl[6]  = '{1'b1, 8'h04, 32'hFF,        32'h0, 1'b1};
    tbl[7]  = '{1'b0, 8'h04, 32'h0,         32'h5, 1'b0};
    tbl[8]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 8'h08, 32'h0,         32'hF, 1'b0};
    tbl[10] = '{1'b1, 8'h08, 32'h0,         32'h0, 1'b0};
    tbl[11] = '{1'b1, 8'h00, 32'h6,         32'h0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 32'h0,         32'h6, 1'b0};
    tbl[13] = '{1'b1, 8'h00, 32'hE,         32'h0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 32'h0,         32'h6, 1'b0};
    tbl[15] = '{1'b1, 8'h00, 32'h8,         32'h0, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 32'h0,         32'h0, 1'b0};
    tbl[17] = '{1'b0, 8'h10, 32'h0,         32'h0, 1'b0};
    tbl[18] = '{1'b1, 8'h0C, 32'hF,         32'h0, 1'b0};
    tbl[19] = '{1'b0, 8'h0C, 32'h0,         32'h0, 1'b0};

    // Reset
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    ch_ready = 2'b00; model_width = 2'd0; PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Build non-reset state, then reset in the middle of an SR read
    write_cr(32'h5);
    push_tx(0, 32'h1234_5678, 1'b0, 2'b00);
    apb_chk("ier_all", 1'b1, 8'h08, 32'hF, 32'h0, 1'b0);
    @(posedge PCLK); #1 ch_ready = 2'b10;
    @(posedge PCLK); #1 ch_ready = 2'b00;
    @(negedge PCLK);
    check("irq_pre_rst", 32'(irq), 32'h1);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    exp_q0.delete(); exp_q1.delete(); model_width = 2'd0;
    #1;
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_valid", 32'(ch_valid), 32'h0);
    check("rst_pready", 32'(PREADY), 32'h1);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;

    // Register map and error decode table
    for (int i = 0; i < 20; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 2'b00, rd, err);
      check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
    end

    // Fill to full, then overflow
    write_cr(32'h0);
    for (int i = 0; i < 9; i++) push_tx(0, $urandom, (i == 8), 2'b00);
    apb_chk("sr_full", 1'b0, 8'h04, 32'h0, 32'h6, 1'b0);
    apb_chk("isr_ovf", 1'b0, 8'h0C, 32'h0, 32'h4, 1'b0);
    @(negedge PCLK) check("irq_masked", 32'(irq), 32'h0);
    apb_chk("ier_ovf", 1'b1, 8'h08, 32'h4, 32'h0, 1'b0);
    @(negedge PCLK) check("irq_ovf", 32'(irq), 32'h1);
    apb_chk("isr_w1c", 1'b1, 8'h0C, 32'h4, 32'h0, 1'b0);
    @(negedge PCLK) check("irq_clr", 32'(irq), 32'h0);
    ch_ready = 2'b01;
    write_cr(32'h1);
    wait_drain();
    ch_ready = 2'b00;
    apb_chk("isr_unr", 1'b0, 8'h0C, 32'h0, 32'h1, 1'b0);
    apb_chk("isr_clr1", 1'b1, 8'h0C, 32'hF, 32'h0, 1'b0);

    // Ordering and width masking with a ready serializer
    ch_ready = 2'b01;
    push_tx(0, 32'hAABB_CCDD, 1'b0, 2'b00);
    push_tx(0, 32'h1122_3344, 1'b0, 2'b00);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK) check("valid_after", 32'(ch_valid[0]), 32'h0);
    apb(1'b0, 8'h0C, 32'h0, 2'b00, rd, err);
    check("isr_unr_bit", rd & 32'h1, 32'h1);
    write_cr(32'h3);
    push_tx(0, 32'hAABB_CCDD, 1'b0, 2'b00);
    write_cr(32'h5);
    push_tx(0, 32'hAABB_CCDD, 1'b0, 2'b00);
    write_cr(32'h7);
    push_tx(0, 32'h9876_5432, 1'b0, 2'b00);
    wait_drain();
    // Underrun set in the same cycle as its W1C keeps the bit
    apb_chk("isr_w1c_race", 1'b1, 8'h0C, 32'hF, 32'h0, 1'b0);
    apb_chk("isr_race_rd", 1'b0, 8'h0C, 32'h0, 32'h1, 1'b0);
    ch_ready = 2'b00;
    apb_chk("isr_clr2", 1'b1, 8'h0C, 32'hF, 32'h0, 1'b0);
    apb_chk("isr_zero", 1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);

    // Simultaneous push/pop at four entries across pointer wrap
    write_cr(32'h5);
    for (int i = 0; i < 4; i++) push_tx(0, $urandom, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) push_tx(0, $urandom, 1'b0, 2'b01);
    apb_chk("sr_mid", 1'b0, 8'h04, 32'h0, 32'h4, 1'b0);
    for (int i = 0; i < 4; i++) push_tx(0, $urandom, 1'b0, 2'b00);
    apb_chk("sr_full2", 1'b0, 8'h04, 32'h0, 32'h6, 1'b0);
    push_tx(0, 32'hFFFF_FFFF, 1'b1, 2'b00);
    ch_ready = 2'b01;
    wait_drain();
    ch_ready = 2'b00;
    apb_chk("isr_clr3", 1'b1, 8'h0C, 32'hF, 32'h0, 1'b0);

    // Flush while both streams pop
    write_cr(32'h1);
    push_tx(0, 32'h0000_1111, 1'b0, 2'b00);
    push_tx(0, 32'h0000_2222, 1'b0, 2'b00);
    push_tx(1, 32'h0000_3333, 1'b0, 2'b00);
    push_tx(1, 32'h0000_4444, 1'b0, 2'b00);
    apb(1'b1, 8'h00, 32'h9, 2'b11, rd, err);
    check("flush_err", 32'(err), 32'h0);
    model_width = 2'd0;
    exp_q0.delete(); exp_q1.delete();
    @(negedge PCLK) check("flush_valid", 32'(ch_valid), 32'h0);
    apb_chk("flush_sr", 1'b0, 8'h04, 32'h0, 32'h5, 1'b0);
    apb_chk("flush_cr", 1'b0, 8'h00, 32'h0, 32'h1, 1'b0);
    ch_ready = 2'b11;
    repeat (4) @(posedge PCLK);
    #1 ch_ready = 2'b00;
    apb_chk("isr_clr4", 1'b1, 8'h0C, 32'hF, 32'h0, 1'b0);

    // Disable keeps contents and hides the stream
    push_tx(0, 32'h0000_5A5A, 1'b0, 2'b00);
    @(negedge PCLK) check("dis_valid_on", 32'(ch_valid), 32'h1);
    write_cr(32'h0);
    @(negedge PCLK) check("dis_valid_off", 32'(ch_valid), 32'h0);
    apb_chk("dis_sr", 1'b0, 8'h04, 32'h0, 32'h4, 1'b0);
    ch_ready = 2'b01;
    write_cr(32'h1);
    wait_drain();
    ch_ready = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
